// File: rtl/inst_buffer_pkg.sv
// Shared field widths and the packed entry layout for the decode-to-dispatch instruction buffer.
package inst_buffer_pkg;

    localparam int OPT_WID      = 7;
    localparam int FUNCT3_WID   = 3;
    localparam int REG_WID      = 6;
    localparam int XLEN         = 32;
    localparam int IB_ENTRY_WID = OPT_WID + FUNCT3_WID + 3 * REG_WID + XLEN;

    // Field order is MSB first: {opt, funct, rs1, rs2, rd, imm}.
    typedef struct packed {
        logic [OPT_WID-1:0]    opt;
        logic [FUNCT3_WID-1:0] funct;
        logic [REG_WID-1:0]    rs1;
        logic [REG_WID-1:0]    rs2;
        logic [REG_WID-1:0]    rd;
        logic [XLEN-1:0]       imm;
    } ib_entry_t;

endpackage

// File: rtl/inst_buffer_ib_ram.sv
// Entry storage: one synchronous write port, one asynchronous read port, no reset.
module ib_ram
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH_LOG = 3
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [DEPTH_LOG-1:0]    waddr,
    input  logic [IB_ENTRY_WID-1:0] wdata,
    input  logic [DEPTH_LOG-1:0]    raddr,
    output logic [IB_ENTRY_WID-1:0] rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG;

    logic [IB_ENTRY_WID-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_buffer.sv
// Circular queue of decoded instructions between decode and dispatch, with flush and
// back-pressure; the head entry is shown to dispatch masked to zero when the queue is empty.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH_LOG = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [OPT_WID-1:0]    id_opt,
    input  logic [FUNCT3_WID-1:0] id_funct,
    input  logic [REG_WID-1:0]    id_rs1,
    input  logic [REG_WID-1:0]    id_rs2,
    input  logic [REG_WID-1:0]    id_rd,
    input  logic [XLEN-1:0]       id_imm,
    output logic                  id_vacant,
    input  logic                  ds_ready,
    output logic                  ds_valid,
    output logic [OPT_WID-1:0]    ds_opt,
    output logic [FUNCT3_WID-1:0] ds_funct,
    output logic [REG_WID-1:0]    ds_rs1,
    output logic [REG_WID-1:0]    ds_rs2,
    output logic [REG_WID-1:0]    ds_rd,
    output logic [XLEN-1:0]       ds_imm,
    output logic [DEPTH_LOG:0]    ib_count
);

    localparam int CNT_W = DEPTH_LOG + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(1 << DEPTH_LOG);

    logic [DEPTH_LOG-1:0] head_q, head_d;
    logic [DEPTH_LOG-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic                    push, pop, ram_we;
    ib_entry_t               wr_entry, rd_entry, head_entry;
    logic [IB_ENTRY_WID-1:0] rd_bits;

    // Vacancy comes from registered occupancy only, so there is no ds_ready -> id_vacant path.
    assign id_vacant = (count_q != FULL_CNT);
    assign ds_valid  = (count_q != '0);
    assign push      = id_valid & id_vacant;
    assign pop       = ds_valid & ds_ready;
    assign ram_we    = push & ~flush & ~rst;

    assign wr_entry = '{opt: id_opt, funct: id_funct, rs1: id_rs1,
                        rs2: id_rs2, rd: id_rd, imm: id_imm};

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rst || flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
    end

    ib_ram #(.DEPTH_LOG(DEPTH_LOG)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (tail_q),
        .wdata (wr_entry),
        .raddr (head_q),
        .rdata (rd_bits)
    );

    // Stale storage contents never leak to dispatch while the queue is empty.
    assign rd_entry   = ib_entry_t'(rd_bits);
    assign head_entry = ds_valid ? rd_entry : '0;

    assign ds_opt   = head_entry.opt;
    assign ds_funct = head_entry.funct;
    assign ds_rs1   = head_entry.rs1;
    assign ds_rs2   = head_entry.rs2;
    assign ds_rd    = head_entry.rd;
    assign ds_imm   = head_entry.imm;
    assign ib_count = count_q;

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: reset, ordering, full back-pressure, wrap, flush, field fidelity.
module tb_inst_buffer;

    logic        clk = 1'b0;
    logic        rst, flush, id_valid, ds_ready;
    logic [6:0]  id_opt;
    logic [2:0]  id_funct;
    logic [5:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_imm;
    logic        id_vacant, ds_valid;
    logic [6:0]  ds_opt;
    logic [2:0]  ds_funct;
    logic [5:0]  ds_rs1, ds_rs2, ds_rd;
    logic [31:0] ds_imm;
    logic [3:0]  ib_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inst_buffer #(.DEPTH_LOG(3)) dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
        .id_opt(id_opt), .id_funct(id_funct), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_imm(id_imm), .id_vacant(id_vacant), .ds_ready(ds_ready),
        .ds_valid(ds_valid), .ds_opt(ds_opt), .ds_funct(ds_funct), .ds_rs1(ds_rs1),
        .ds_rs2(ds_rs2), .ds_rd(ds_rd), .ds_imm(ds_imm), .ib_count(ib_count)
    );

    // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; id_valid = 1'b0; ds_ready = 1'b0;
        id_opt = '0; id_funct = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_imm = '0;
        cyc(); cyc();
        rst = 1'b0;
        checks++; if (id_vacant !== 1'b1) begin errors++; $display("FAIL reset_vacant got=%0b exp=1", id_vacant); end
        checks++; if (ds_valid !== 1'b0) begin errors++; $display("FAIL reset_ds_valid got=%0b exp=0", ds_valid); end
        checks++; if (ds_imm !== 32'd0) begin errors++; $display("FAIL reset_ds_imm got=%0h exp=0", ds_imm); end
        checks++; if (ib_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", ib_count); end
    endtask

    task automatic test_basic();
        for (int k = 1; k <= 3; k++) begin
            id_valid = 1'b1; id_imm = 32'(k);
            cyc();
        end
        id_valid = 1'b0;
        checks++; if (ib_count !== 4'd3) begin errors++; $display("FAIL basic_count got=%0d exp=3", ib_count); end
        checks++; if (ds_imm !== 32'd1) begin errors++; $display("FAIL basic_head got=%0d exp=1", ds_imm); end
        ds_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (ds_valid !== 1'b1 || ds_imm !== 32'(k)) begin
                errors++; $display("FAIL basic_pop%0d got valid=%0b imm=%0d exp valid=1 imm=%0d", k, ds_valid, ds_imm, k);
            end
            cyc();
        end
        ds_ready = 1'b0;
        checks++; if (ds_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got=%0b exp=0", ds_valid); end
    endtask

    task automatic test_full();
        for (int k = 0; k < 8; k++) begin
            id_valid = 1'b1; id_imm = 32'(10 + k);
            cyc();
        end
        checks++; if (ib_count !== 4'd8) begin errors++; $display("FAIL full_count got=%0d exp=8", ib_count); end
        checks++; if (id_vacant !== 1'b0) begin errors++; $display("FAIL full_vacant got=%0b exp=0", id_vacant); end
        id_imm = 32'd99;
        cyc();
        checks++; if (ib_count !== 4'd8) begin errors++; $display("FAIL full_ninth_dropped got=%0d exp=8", ib_count); end
        // Pop while full: the held 9th entry must still not be written this cycle.
        ds_ready = 1'b1;
        checks++; if (ds_imm !== 32'd10) begin errors++; $display("FAIL full_pop_head got=%0d exp=10", ds_imm); end
        cyc();
        ds_ready = 1'b0;
        checks++; if (id_vacant !== 1'b1 || ib_count !== 4'd7) begin
            errors++; $display("FAIL full_after_pop got vacant=%0b count=%0d exp vacant=1 count=7", id_vacant, ib_count);
        end
        cyc();
        id_valid = 1'b0;
        checks++; if (ib_count !== 4'd8) begin errors++; $display("FAIL full_ninth_accepted got=%0d exp=8", ib_count); end
        ds_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (ds_imm !== ((k == 8) ? 32'd99 : 32'(10 + k))) begin
                errors++; $display("FAIL full_drain%0d got=%0d exp=%0d", k, ds_imm, (k == 8) ? 99 : 10 + k);
            end
            cyc();
        end
        ds_ready = 1'b0;
        checks++; if (ib_count !== 4'd0) begin errors++; $display("FAIL full_drained got=%0d exp=0", ib_count); end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 2; k++) begin
            id_valid = 1'b1; id_imm = 32'(k);
            cyc();
        end
        ds_ready = 1'b1;
        for (int k = 2; k < 22; k++) begin
            id_imm = 32'(k);
            checks++;
            if (ds_imm !== 32'(k - 2) || ib_count !== 4'd2) begin
                errors++; $display("FAIL stream%0d got imm=%0d count=%0d exp imm=%0d count=2", k, ds_imm, ib_count, k - 2);
            end
            cyc();
        end
        id_valid = 1'b0;
        for (int k = 20; k < 22; k++) begin
            checks++; if (ds_imm !== 32'(k)) begin errors++; $display("FAIL stream_tail%0d got=%0d exp=%0d", k, ds_imm, k); end
            cyc();
        end
        ds_ready = 1'b0;
        checks++; if (ds_valid !== 1'b0) begin errors++; $display("FAIL stream_empty got=%0b exp=0", ds_valid); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 5; k++) begin
            id_valid = 1'b1; id_imm = 32'(50 + k);
            cyc();
        end
        id_imm = 32'd77; ds_ready = 1'b1; flush = 1'b1;
        cyc();
        flush = 1'b0; id_valid = 1'b0; ds_ready = 1'b0;
        checks++; if (ib_count !== 4'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", ib_count); end
        checks++; if (ds_valid !== 1'b0 || ds_imm !== 32'd0) begin
            errors++; $display("FAIL flush_masked got valid=%0b imm=%0h exp valid=0 imm=0", ds_valid, ds_imm);
        end
        id_valid = 1'b1; id_imm = 32'd88;
        cyc();
        id_valid = 1'b0;
        checks++; if (ds_valid !== 1'b1 || ds_imm !== 32'd88 || ib_count !== 4'd1) begin
            errors++; $display("FAIL flush_repush got valid=%0b imm=%0d count=%0d exp 1/88/1", ds_valid, ds_imm, ib_count);
        end
        ds_ready = 1'b1;
        cyc();
        ds_ready = 1'b0;
    endtask

    task automatic test_vector_rst();
        id_valid = 1'b1; id_opt = 7'h57; id_funct = 3'h5; id_rs1 = 6'h21;
        id_rs2 = 6'h3F; id_rd = 6'h2A; id_imm = 32'hDEADBEEF;
        cyc();
        id_opt = 7'h13; id_funct = 3'h0; id_rs1 = 6'h01; id_rs2 = 6'h02; id_rd = 6'h03;
        checks++; if ({ds_opt, ds_funct, ds_rs1, ds_rs2, ds_rd, ds_imm} !== {7'h57, 3'h5, 6'h21, 6'h3F, 6'h2A, 32'hDEADBEEF}) begin
            errors++; $display("FAIL vec_fields got opt=%0h f=%0h rs1=%0h rs2=%0h rd=%0h imm=%0h exp 57/5/21/3f/2a/deadbeef",
                               ds_opt, ds_funct, ds_rs1, ds_rs2, ds_rd, ds_imm);
        end
        cyc(); cyc(); cyc();
        id_valid = 1'b0;
        checks++; if (ib_count !== 4'd4) begin errors++; $display("FAIL vec_count got=%0d exp=4", ib_count); end
        rst = 1'b1; id_valid = 1'b1; ds_ready = 1'b1; flush = 1'b1;
        cyc();
        rst = 1'b0; id_valid = 1'b0; ds_ready = 1'b0; flush = 1'b0;
        checks++; if (ib_count !== 4'd0 || ds_valid !== 1'b0 || id_vacant !== 1'b1 || ds_rd !== 6'd0) begin
            errors++; $display("FAIL rst_midstream got count=%0d valid=%0b vacant=%0b rd=%0h exp 0/0/1/0",
                               ib_count, ds_valid, id_vacant, ds_rd);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_stream();
        test_flush();
        test_vector_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
